stopwatch_display: RTL and testbench

//  Consumer of the stopwatch counter's sec/min values. Drives a 4-digit multiplexed

---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/stopwatch_display_seg7_decode.sv | 22 ++
 rtl/stopwatch_display.sv | 121 ++++++++++++
 tb/tb_stopwatch_display.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path.
//   SEG_BLANK / SEG_DASH : active-low segment patterns {g,f,e,d,c,b,a}
//   digit_seg()          : active-low pattern for BCD digit 0..9
//   digit_idx_t          : scan slot index (0 = sec ones .. 3 = min tens)
package stopwatch_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t IDX_SEC_ONES = 2'd0;
  localparam digit_idx_t IDX_MIN_ONES = 2'd2;
  localparam digit_idx_t IDX_LAST     = 2'd3;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// Combinational BCD to seven-segment decoder.
//   digit : BCD value 0..9 (10..15 decode as blank)
//   blank : force all segments off (takes priority over dash)
//   dash  : show a single dash (segment g)
//   seg   : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (blank)     seg = SEG_BLANK;
    else if (dash) seg = SEG_DASH;
    else           seg = digit_seg(digit);
  end

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed MM.SS display driver with adjust-mode field flashing.
//   clk, rst_n : clock, asynchronous active-low reset
//   sec, min   : counter values, 0..59 legal; 60..63 render as dashes
//   adj, sel   : adjust mode / field select (1 = seconds, 0 = minutes)
//   seg, dp, an: registered active-low segment, decimal point and anode drives
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rcnt;
  logic [BW-1:0] bcnt;
  digit_idx_t    idx;
  logic          ghost;     // next output cycle is the anti-ghosting gap
  logic          first;     // first clock after reset release
  logic          phase_on;
  logic [5:0]    snap_sec, snap_min;

  logic          tick;
  logic          snap_ld;
  logic [5:0]    val;
  logic [3:0]    digit;
  logic          field_sec;
  logic          blank;
  logic [6:0]    dec_seg;

  assign tick    = (rcnt == RMAX);
  // Whole frame comes from one sample: load only when the scan restarts.
  assign snap_ld = first | (tick & (idx == IDX_LAST));

  // Refresh, scan index and snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt     <= '0;
      idx      <= IDX_SEC_ONES;
      first    <= 1'b1;
      snap_sec <= '0;
      snap_min <= '0;
    end else begin
      first <= 1'b0;
      rcnt  <= tick ? '0 : rcnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
      if (snap_ld) begin
        snap_sec <= sec;
        snap_min <= min;
      end
    end
  end

  // Blink timer: parked at 0 / ON whenever adjust is off, so entering
  // adjust always starts with a full visible phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (!adj) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (bcnt == BMAX) begin
      bcnt     <= '0;
      phase_on <= ~phase_on;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // Digit select and BCD split on the snapshot
  always_comb begin
    field_sec = ~idx[1];
    val       = field_sec ? snap_sec : snap_min;
    digit     = idx[0] ? 4'(val / 6'd10) : 4'(val % 6'd10);
    blank     = adj & ~phase_on & (sel == field_sec);
  end

  seg7_decode u_dec (
    .digit (digit),
    .blank (blank),
    .dash  (val >= 6'd60),
    .seg   (dec_seg)
  );

  // Output registers. ghost starts set so the first cycle after reset is
  // a gap cycle, same as every cycle following a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghost <= 1'b1;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      ghost <= tick;
      if (ghost) begin
        an  <= 4'b1111;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= dec_seg;
        dp  <= (idx != IDX_MIN_ONES);
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

  localparam int R = 4;
  localparam int B = 16;
  localparam int HN = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sec = '0, min = '0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  stopwatch_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .sec(sec), .min(min),
    .adj(adj), .sel(sel), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // History of inputs seen at each clock edge n since reset release, plus
  // whether adjust mode has been on long enough to be in an OFF phase.
  int       n = 0;
  int       run = 0;
  int       sec_h[HN];
  int       min_h[HN];
  bit       adj_h[HN];
  bit       sel_h[HN];
  bit       on_h[HN];
  logic [6:0] lit[10];  // active-high gfedcba

  initial begin
    lit[0] = 7'h3F; lit[1] = 7'h06; lit[2] = 7'h5B; lit[3] = 7'h4F; lit[4] = 7'h66;
    lit[5] = 7'h6D; lit[6] = 7'h7D; lit[7] = 7'h07; lit[8] = 7'h7F; lit[9] = 7'h6F;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      run = 0;
    end else if (n < HN - 1) begin
      n = n + 1;
      sec_h[n] = int'(sec);
      min_h[n] = int'(min);
      adj_h[n] = adj;
      sel_h[n] = sel;
      on_h[n]  = ((run / B) % 2) == 0;
      run = adj ? run + 1 : 0;
    end
  end

  // Expected {an, seg, dp} after the m-th edge since release.
  function automatic logic [11:0] expv(int m);
    int k, slot, f, se, val, d;
    bit fsec;
    logic [3:0] ea;
    logic [6:0] es;
    if (m == 0) return {4'hF, 7'h7F, 1'b1};
    k = m - 1;
    if (k % R == 0) return {4'hF, 7'h7F, 1'b1};
    slot = (k / R) % 4;
    f    = k / (4 * R);
    se   = (f == 0) ? 1 : 4 * R * f;
    fsec = slot < 2;
    val  = fsec ? sec_h[se] : min_h[se];
    d    = (slot % 2 == 0) ? val % 10 : val / 10;
    if (adj_h[m] && !on_h[m] && (sel_h[m] == fsec)) es = 7'h7F;
    else if (val >= 60)                              es = 7'h3F;
    else                                             es = ~lit[d];
    ea = 4'hF;
    ea[slot] = 1'b0;
    return {ea, es, (slot == 2) ? 1'b0 : 1'b1};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; sec = 0; min = 0; adj = 0; sel = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL reset_hold got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL reset_gap got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    @(negedge clk);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'h40, 1'b1}) begin
      errors++; $display("FAIL reset_first got an=%b seg=%h dp=%b want an=1110 seg=40 dp=1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    logic [11:0] e;
    int dp_slots = 0;
    sec = 37; min = 5;
    repeat (48) begin
      @(negedge clk);
      e = expv(n);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++; $display("FAIL scan n=%0d got %b/%h/%b want %b/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (dp == 1'b0) dp_slots++;
    end
    // 48 cycles = 3 frames, each with 3 driven dp cycles in the 1011 slot
    checks++;
    if (dp_slots !== 9) begin
      errors++; $display("FAIL scan_dp_count got %0d want 9", dp_slots);
    end
  endtask

  task automatic test_coherence();
    logic [11:0] e;
    int guard = 0;
    // Move to the middle of the sec-tens slot (known from the edge count).
    while (!((((n - 1) / R) % 4 == 1) && ((n - 1) % R == 2)) && guard < 100) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++; $display("FAIL coherence_align got timeout want slot1");
    end
    sec = 38;
    repeat (40) begin
      @(negedge clk);
      e = expv(n);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++; $display("FAIL coherence n=%0d got %b/%h/%b want %b/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_blink();
    logic [11:0] e;
    int blanked = 0;
    adj = 1; sel = 1;
    repeat (96) begin
      @(negedge clk);
      e = expv(n);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++; $display("FAIL blink_sec n=%0d got %b/%h/%b want %b/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (an[1:0] != 2'b11 && seg == 7'h7F) blanked++;
      checks++;
      if (an[3:2] != 2'b11 && seg === 7'h7F) begin
        errors++; $display("FAIL blink_min_blanked n=%0d got seg=%h want lit", n, seg);
      end
    end
    checks++;
    if (blanked == 0) begin
      errors++; $display("FAIL blink_seen got %0d blanked sec cycles want >0", blanked);
    end
    sel = 0;
    repeat (40) begin
      @(negedge clk);
      e = expv(n);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++; $display("FAIL blink_min n=%0d got %b/%h/%b want %b/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
    adj = 0;
    repeat (24) begin
      @(negedge clk);
      e = expv(n);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++; $display("FAIL blink_off n=%0d got %b/%h/%b want %b/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [11:0] e;
    logic [5:0] sv[4];
    logic [5:0] mv[4];
    sv[0] = 59; mv[0] = 59;
    sv[1] = 0;  mv[1] = 0;
    sv[2] = 17; mv[2] = 61;
    sv[3] = 63; mv[3] = 60;
    for (int t = 0; t < 4; t++) begin
      sec = sv[t]; min = mv[t];
      repeat (36) begin
        @(negedge clk);
        e = expv(n);
        checks++;
        if ({an, seg, dp} !== e) begin
          errors++; $display("FAIL boundary%0d n=%0d got %b/%h/%b want %b/%h/%b", t, n, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      e = expv(n);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++; $display("FAIL random n=%0d got %b/%h/%b want %b/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if ($urandom_range(0, 9) == 0) begin
        sec = 6'($urandom_range(0, 63));
        min = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sel = ~sel;
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    adj = 1; sel = 1; sec = 42; min = 13;
    repeat (27) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL async_reset got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      e = expv(n);
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++; $display("FAIL after_reset n=%0d got %b/%h/%b want %b/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (n == 2) begin
        checks++;
        if (an !== 4'b1110) begin
          errors++; $display("FAIL after_reset_idx0 got an=%b want 1110", an);
        end
      end
    end
    adj = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherence();
    test_blink();
    test_boundary();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
